mul16_shift_add: RTL and testbench

Sequential 16×16 unsigned multiplier producing a 32-bit product by radix-2 shift-and-add, one partial product per clock. Each partial sum goes through one instance of the team's 16-bit carry-lookahead adder, `adder_CLA`, with `c_in` tied to 0. The block is the datapath stage directly upstream of `adder_CLA`: it generates the adder's operands every cycle and consumes its sum and carry-out. Operands enter and results leave over valid/ready handshakes.

---
 rtl/mul16_shift_add.sv | 158 +++++++++++++++
 tb/tb_mul16_shift_add.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mul16_shift_add.sv
// Sequential 16x16 unsigned multiplier: radix-2 shift-and-add, one partial product per clock,
// with each partial sum formed by a 16-bit carry-lookahead adder (adder_CLA, defined below).
`timescale 1ns/1ps

module adder_CLA (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] sum,
   output logic        c_out
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [3:0]  gc;

   assign g = a & b;
   assign p = a ^ b;

   // Per-nibble group generate/propagate, and bit carries derived from each group's carry-in.
   genvar grp;
   generate
      for (grp = 0; grp < 4; grp++) begin : g_group
         assign gg[grp] = g[4*grp+3]
                        | (p[4*grp+3] & g[4*grp+2])
                        | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                        | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp]);
         assign gp[grp] = &p[4*grp +: 4];

         assign c[4*grp]   = gc[grp];
         assign c[4*grp+1] = g[4*grp] | (p[4*grp] & gc[grp]);
         assign c[4*grp+2] = g[4*grp+1]
                           | (p[4*grp+1] & g[4*grp])
                           | (p[4*grp+1] & p[4*grp] & gc[grp]);
         assign c[4*grp+3] = g[4*grp+2]
                           | (p[4*grp+2] & g[4*grp+1])
                           | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                           | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & gc[grp]);
      end
   endgenerate

   // Second lookahead level: every group carry is flattened directly from c_in.
   assign gc[0] = c_in;
   assign gc[1] = gg[0] | (gp[0] & c_in);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & c_in);
   assign c_out = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

   assign sum = p ^ c;

endmodule

module mul16_shift_add (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] mcand;
   logic [15:0] acc_hi;
   logic [15:0] acc_lo;
   logic [3:0]  cnt;
   logic [15:0] sum;
   logic        c_out;
   logic [15:0] nxt_hi;
   logic [15:0] nxt_lo;

   adder_CLA u_adder (
      .a     (acc_hi),
      .b     (mcand),
      .c_in  (1'b0),
      .sum   (sum),
      .c_out (c_out)
   );

   // The adder's carry-out becomes the new top bit, so the 32-bit accumulator never overflows.
   always_comb begin
      nxt_hi = acc_hi;
      nxt_lo = acc_lo;
      if (acc_lo[0]) begin
         {nxt_hi, nxt_lo} = {c_out, sum, acc_lo[15:1]};
      end else begin
         {nxt_hi, nxt_lo} = {1'b0, acc_hi, acc_lo[15:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)     state_next = BUSY;
         BUSY:    if (cnt == 4'd15) state_next = DONE;
         DONE:    if (out_ready)    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= a;
                  acc_lo <= b;
                  acc_hi <= '0;
                  cnt    <= '0;
               end
            end
            BUSY: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               cnt    <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  product <= {nxt_hi, nxt_lo};
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_mul16_shift_add.sv
// Directed, table-driven bench for mul16_shift_add: product values, fixed 16-cycle latency,
// backpressure, ignored inputs while busy, and asynchronous reset in the middle of an operation.
`timescale 1ns/1ps

module tb_mul16_shift_add;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;

   int checks;
   int errors;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] expected;
   } vec_t;

   vec_t vecs[8];

   mul16_shift_add dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Present operands on a falling edge; they are accepted at the next rising edge.
   task automatic applyStimulus(input logic [15:0] a_v, input logic [15:0] b_v);
      @(negedge clk);
      checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      a        = a_v;
      b        = b_v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts rising edges after the accept until out_valid is seen, bounded at 40.
   task automatic waitResult(input int start, output int lat);
      lat = start;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) break;
      end
   endtask

   initial begin
      int lat;
      checks    = 0;
      errors    = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      rst_n     = 1'b1;

      vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
      vecs[2] = '{16'h1234, 16'h0000, 32'h00000000};
      vecs[3] = '{16'h8000, 16'h0002, 32'h00010000};
      vecs[4] = '{16'hABCD, 16'h1234, 32'h0C374FA4};
      vecs[5] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
      vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
      vecs[7] = '{16'h0000, 16'hFFFF, 32'h00000000};

      #1 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("reset_in_ready",  {31'd0, in_ready},  32'd1);
         checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
         checkOutput("reset_product",   product,            32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_in_ready",  {31'd0, in_ready},  32'd1);
      checkOutput("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("post_reset_product",   product,            32'd0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b);
         waitResult(0, lat);
         checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
         checkOutput($sformatf("vec%0d_product", i), product, vecs[i].expected);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_in_ready_after", i), {31'd0, in_ready}, 32'd1);
         checkOutput($sformatf("vec%0d_out_valid_after", i), {31'd0, out_valid}, 32'd0);
      end

      $display("[TB] backpressure sequence");
      out_ready = 1'b0;
      applyStimulus(16'h00FF, 16'h0101);
      waitResult(0, lat);
      checkOutput("bp_latency", 32'(lat), 32'd16);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_product",   product,            32'h0000FFFF);
         checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("bp_in_ready",  {31'd0, in_ready},  32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
      checkOutput("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

      $display("[TB] ignored input sequence");
      applyStimulus(16'h0003, 16'h0007);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         a        = 16'hAAAA;
         b        = 16'h5555;
         in_valid = ~in_valid;
         checkOutput("busy_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      waitResult(lat, lat);
      checkOutput("ignored_latency", 32'(lat), 32'd16);
      checkOutput("ignored_product", product,  32'd21);
      @(negedge clk);

      $display("[TB] reset mid-operation sequence");
      applyStimulus(16'd100, 16'd200);
      for (int i = 0; i < 7; i++) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midrst_product",   product,            32'd0);
      checkOutput("midrst_in_ready",  {31'd0, in_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      checkOutput("midrst_no_output", {31'd0, out_valid}, 32'd0);
      applyStimulus(16'd7, 16'd9);
      waitResult(0, lat);
      checkOutput("after_rst_latency", 32'(lat), 32'd16);
      checkOutput("after_rst_product", product,  32'd63);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
